// File: rtl/tstamp_ctrl_if.sv
// Command handshake bundle between register logic and tstamp_ctrl.
// Carries the op/data request, its ready back-pressure and the slew abort.
interface tstamp_ctrl_if #(
  parameter int TIMESTAMP_WIDTH = 64
);
  logic                       cmd_valid;
  logic                       cmd_ready;
  logic [1:0]                 cmd_op;
  logic [TIMESTAMP_WIDTH-1:0] cmd_data;
  logic                       cmd_abort;

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_abort,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_abort,
    output cmd_ready
  );
endinterface

// File: rtl/tstamp_ctrl.sv
// Global timestamp owner: free-run increment, load, slewed adjust,
// command snapshots and external sync captures.
module tstamp_ctrl #(
  parameter int TIMESTAMP_WIDTH = 64,
  parameter int SLEW_WIDTH      = 32,
  parameter int DEFAULT_INC     = 1
) (
  input  logic                       axi_aclk,
  input  logic                       axi_resetn,
  input  logic                       cfg_enable,
  input  logic                       cfg_inc_wr,
  input  logic [31:0]                cfg_inc_data,
  tstamp_ctrl_if.slave               cmd_if,
  input  logic                       ext_sync,
  output logic [TIMESTAMP_WIDTH-1:0] tstamp,
  output logic [TIMESTAMP_WIDTH-1:0] snap_value,
  output logic                       snap_valid,
  output logic [TIMESTAMP_WIDTH-1:0] sync_value,
  output logic                       sync_valid,
  output logic                       busy,
  output logic [SLEW_WIDTH-1:0]      slew_remaining,
  output logic                       cmd_err
);
  localparam int TW = TIMESTAMP_WIDTH;
  localparam int SW = SLEW_WIDTH;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_ADJ  = 2'b10;
  localparam logic [1:0] OP_SNAP = 2'b11;

  typedef enum logic {IDLE, SLEW} state_e;

  state_e          state_q;
  logic [TW-1:0]   ts_q, ts_d, ts_inc;
  logic [TW-1:0]   snap_q, sync_q;
  logic            snapv_q, syncv_q, err_q;
  logic            neg_q, sync_d1_q;
  logic [SW-1:0]   rem_q;
  logic [31:0]     inc_q;

  logic            accept, rise, slewing;
  logic            adj_neg;
  logic [SW-1:0]   adj_mag;

  assign cmd_if.cmd_ready = (state_q == IDLE);

  assign accept  = cmd_if.cmd_valid & (state_q == IDLE);
  assign rise    = ext_sync & ~sync_d1_q;
  assign slewing = (state_q == SLEW) & ~cmd_if.cmd_abort;
  assign adj_neg = cmd_if.cmd_data[TW-1];
  assign adj_mag = cmd_if.cmd_data[SW-1:0];
  assign ts_inc  = ts_q + TW'(inc_q);

  // LOAD beats the enable gate; slew trims the increment by one
  always_comb begin
    ts_d = ts_inc;
    if (accept && cmd_if.cmd_op == OP_LOAD)
      ts_d = cmd_if.cmd_data;
    else if (!cfg_enable)
      ts_d = ts_q;
    else if (slewing)
      ts_d = neg_q ? ts_inc - TW'(1) : ts_inc + TW'(1);
  end

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_q   <= IDLE;
      ts_q      <= '0;
      snap_q    <= '0;
      sync_q    <= '0;
      snapv_q   <= 1'b0;
      syncv_q   <= 1'b0;
      err_q     <= 1'b0;
      neg_q     <= 1'b0;
      sync_d1_q <= 1'b0;
      rem_q     <= '0;
      inc_q     <= 32'(DEFAULT_INC);
    end else begin
      ts_q      <= ts_d;
      sync_d1_q <= ext_sync;
      syncv_q   <= rise;
      snapv_q   <= 1'b0;
      err_q     <= 1'b0;
      if (rise)
        sync_q <= ts_q;
      if (cfg_inc_wr)
        inc_q <= cfg_inc_data;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            unique case (cmd_if.cmd_op)
              OP_NOP, OP_LOAD: ;
              OP_ADJ: begin
                if (adj_mag != '0) begin
                  if (adj_neg && inc_q < 32'd2) begin
                    err_q <= 1'b1;
                  end else begin
                    rem_q   <= adj_mag;
                    neg_q   <= adj_neg;
                    state_q <= SLEW;
                  end
                end
              end
              OP_SNAP: begin
                snap_q  <= ts_q;
                snapv_q <= 1'b1;
              end
            endcase
          end
        end
        SLEW: begin
          if (cmd_if.cmd_abort) begin
            rem_q   <= '0;
            state_q <= IDLE;
          end else if (cfg_enable) begin
            rem_q <= rem_q - SW'(1);
            if (rem_q == SW'(1))
              state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign tstamp         = ts_q;
  assign snap_value     = snap_q;
  assign snap_valid     = snapv_q;
  assign sync_value     = sync_q;
  assign sync_valid     = syncv_q;
  assign busy           = (state_q == SLEW);
  assign slew_remaining = rem_q;
  assign cmd_err        = err_q;
endmodule
